// File: rtl/exam1_operand_recover_if.sv
// Request/response bundle for the exam1 operand-recovery block.
// The master issues a request and consumes the recovered operand; the slave is the block itself.
interface exam1_operand_recover_if #(
    parameter int unsigned WIDTH = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic [1:0]           ctrl;
    logic [2*WIDTH-1:0]   result;
    logic [WIDTH-1:0]     b;
    logic                 out_valid;
    logic                 out_ready;
    logic [WIDTH-1:0]     a_rec;
    logic                 gt_flag;
    logic                 err;

    modport master (
        output in_valid, ctrl, result, b, out_ready,
        input  in_ready, out_valid, a_rec, gt_flag, err
    );

    modport slave (
        input  in_valid, ctrl, result, b, out_ready,
        output in_ready, out_valid, a_rec, gt_flag, err
    );
endinterface

// File: rtl/exam1_operand_recover.sv
// Recovers operand A of the exam1 unit from its result, ctrl code and operand B.
// ctrl 00 runs a sign-magnitude restoring divider; all other codes resolve in one cycle.
module exam1_operand_recover #(
    parameter int unsigned WIDTH = 8
) (
    input logic                    clk,
    input logic                    rst,
    exam1_operand_recover_if.slave bus
);
    localparam int unsigned RW = 2 * WIDTH;
    localparam int unsigned PW = 2 * WIDTH + 1;
    localparam int unsigned CW = $clog2(PW);
    localparam logic [PW-1:0] QMaxPos = {{(PW - WIDTH + 1){1'b0}}, {(WIDTH - 1){1'b1}}};
    localparam logic [PW-1:0] QMaxNeg = {{(PW - WIDTH){1'b0}}, 1'b1, {(WIDTH - 1){1'b0}}};

    typedef enum logic [1:0] {StIdle, StDiv, StDone} state_e;

    state_e           state_q, state_d;
    logic [PW-1:0]    dvd_q, dvd_d, quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d, rem_q, rem_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             qneg_q, qneg_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic             gt_q, gt_d, err_q, err_d;

    // Single-cycle decode of ctrl 01/10/11 straight off the request
    logic [WIDTH-1:0]     hi, lo, x01;
    logic signed [RW-1:0] b_ext, s11, a11;
    logic                 a11_fits;

    assign hi       = bus.result[RW-1:WIDTH];
    assign lo       = bus.result[WIDTH-1:0];
    assign x01      = lo ^ bus.b;
    assign b_ext    = {{WIDTH{bus.b[WIDTH-1]}}, bus.b};
    assign s11      = $signed(bus.result) >>> 2;
    assign a11      = s11 - b_ext;
    assign a11_fits = (&a11[RW-1:WIDTH-1]) || !(|a11[RW-1:WIDTH-1]);

    logic [WIDTH-1:0] qa;
    logic             qgt, qerr;

    always_comb begin
        qa   = '0;
        qgt  = 1'b0;
        qerr = 1'b0;
        unique case (bus.ctrl)
            2'b00: qerr = 1'b1;  // only reaches here with b == 0
            2'b01: begin
                if (hi != (x01 & bus.b)) qerr = 1'b1;
                else qa = x01;
            end
            2'b10: begin
                if (bus.result == RW'(1)) qgt = 1'b1;
                else if (bus.result != '1) qerr = 1'b1;
            end
            2'b11: begin
                if ((bus.result[1:0] != 2'b00) || !a11_fits) qerr = 1'b1;
                else qa = a11[WIDTH-1:0];
            end
        endcase
    end

    // P = result - 3 carries one extra bit so the subtraction never overflows
    logic signed [PW-1:0] p_val;
    logic [PW-1:0]        p_mag;
    logic [WIDTH-1:0]     b_mag;

    assign p_val = {bus.result[RW-1], bus.result} - PW'(3);
    assign p_mag = p_val[PW-1] ? -p_val : p_val;
    assign b_mag = bus.b[WIDTH-1] ? -bus.b : bus.b;

    logic [WIDTH:0]   rem_sh;
    logic             it_ge;
    logic [WIDTH-1:0] it_rem;
    logic [PW-1:0]    it_quo;

    assign rem_sh = {rem_q, dvd_q[PW-1]};
    assign it_ge  = rem_sh >= {1'b0, dvs_q};
    assign it_rem = it_ge ? WIDTH'(rem_sh - {1'b0, dvs_q}) : rem_sh[WIDTH-1:0];
    assign it_quo = {quo_q[PW-2:0], it_ge};

    // Last iteration is resolved in the same cycle it is computed
    logic             fq_neg, f_err;
    logic [WIDTH-1:0] f_a;

    assign fq_neg = qneg_q && (it_quo != '0);
    assign f_err  = (it_rem != '0) || (fq_neg ? (it_quo > QMaxNeg) : (it_quo > QMaxPos));
    assign f_a    = f_err ? '0 : (fq_neg ? -it_quo[WIDTH-1:0] : it_quo[WIDTH-1:0]);

    always_comb begin
        state_d = state_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        cnt_d   = cnt_q;
        qneg_d  = qneg_q;
        a_d     = a_q;
        gt_d    = gt_q;
        err_d   = err_q;
        unique case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    if ((bus.ctrl == 2'b00) && (bus.b != '0)) begin
                        dvd_d   = p_mag;
                        dvs_d   = b_mag;
                        rem_d   = '0;
                        quo_d   = '0;
                        cnt_d   = '0;
                        qneg_d  = p_val[PW-1] ^ bus.b[WIDTH-1];
                        state_d = StDiv;
                    end else begin
                        a_d     = qa;
                        gt_d    = qgt;
                        err_d   = qerr;
                        state_d = StDone;
                    end
                end
            end
            StDiv: begin
                dvd_d = dvd_q << 1;
                rem_d = it_rem;
                quo_d = it_quo;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(PW - 1)) begin
                    a_d     = f_a;
                    gt_d    = 1'b0;
                    err_d   = f_err;
                    state_d = StDone;
                end
            end
            StDone: begin
                if (bus.out_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            dvd_q   <= '0;
            dvs_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            cnt_q   <= '0;
            qneg_q  <= 1'b0;
            a_q     <= '0;
            gt_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            cnt_q   <= cnt_d;
            qneg_q  <= qneg_d;
            a_q     <= a_d;
            gt_q    <= gt_d;
            err_q   <= err_d;
        end
    end

    assign bus.in_ready  = (state_q == StIdle);
    assign bus.out_valid = (state_q == StDone);
    assign bus.a_rec     = a_q;
    assign bus.gt_flag   = gt_q;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_exam1_operand_recover.sv
// Bench for exam1_operand_recover: directed cases, randomized traffic against a brute-force
// inverse model, backpressure and mid-division reset.
module tb_exam1_operand_recover;
    localparam int unsigned W = 8;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    exam1_operand_recover_if #(.WIDTH(W)) bus_if ();

    exam1_operand_recover #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    typedef struct {
        logic [1:0]  c;
        logic [15:0] r;
        logic [7:0]  b;
        logic [7:0]  a;
        logic        gt;
        logic        e;
        int          lat;
    } dir_t;

    dir_t dir_tab [12];

    // Inverse by exhaustive search over every legal A of the forward unit
    function automatic void model(input logic [1:0] c, input logic [15:0] r, input logic [7:0] bb,
                                  output logic [7:0] a, output logic gt, output logic e);
        int rv, bv, f;
        logic [7:0] xb;
        bit found;
        a = 8'h00; gt = 1'b0; e = 1'b0; found = 1'b0;
        rv = int'($signed(r));
        bv = int'($signed(bb));
        if (c == 2'b10) begin
            if (rv == 1) gt = 1'b1;
            else if (rv != -1) e = 1'b1;
        end else if (c == 2'b00 && bv == 0) begin
            e = 1'b1;
        end else begin
            for (int x = -128; x <= 127; x++) begin
                xb = x[7:0];
                if (c == 2'b00) begin
                    f = x * bv + 3;
                    if (f == rv) begin a = xb; found = 1'b1; end
                end else if (c == 2'b01) begin
                    if ({xb & bb, xb ^ bb} == r) begin a = xb; found = 1'b1; end
                end else begin
                    f = (x + bv) * 4;
                    if (f == rv) begin a = xb; found = 1'b1; end
                end
            end
            if (!found) e = 1'b1;
        end
    endfunction

    task automatic do_txn(input logic [1:0] c, input logic [15:0] r, input logic [7:0] bb,
                          output logic [7:0] a, output logic gt, output logic e,
                          output int lat, output int ir_bad, output bit timeout);
        ir_bad = 0; timeout = 1'b0;
        bus_if.ctrl = c; bus_if.result = r; bus_if.b = bb; bus_if.in_valid = 1'b1;
        @(posedge clk); #1;
        bus_if.in_valid = 1'b0;
        bus_if.ctrl = 2'($urandom); bus_if.result = 16'($urandom); bus_if.b = 8'($urandom);
        lat = 1;
        while (!bus_if.out_valid && lat < 40) begin
            if (bus_if.in_ready) ir_bad++;
            @(posedge clk); #1;
            lat++;
        end
        if (!bus_if.out_valid) timeout = 1'b1;
        a = bus_if.a_rec; gt = bus_if.gt_flag; e = bus_if.err;
        bus_if.out_ready = 1'b1;
        @(posedge clk); #1;
        bus_if.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus_if.in_valid = 1'b0; bus_if.out_ready = 1'b0;
        bus_if.ctrl = 2'b00; bus_if.result = 16'h0000; bus_if.b = 8'h00;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        checks++;
        if (bus_if.in_ready !== 1'b1) begin
            failures++; $display("FAIL reset_in_ready got=%b exp=1", bus_if.in_ready);
        end
        checks++;
        if (bus_if.out_valid !== 1'b0) begin
            failures++; $display("FAIL reset_out_valid got=%b exp=0", bus_if.out_valid);
        end
        checks++;
        if ({bus_if.a_rec, bus_if.gt_flag, bus_if.err} !== 10'h000) begin
            failures++;
            $display("FAIL reset_outputs got a=%h gt=%b err=%b exp all zero",
                     bus_if.a_rec, bus_if.gt_flag, bus_if.err);
        end
    endtask

    task automatic test_directed();
        logic [7:0] a; logic gt, e; int lat, irb; bit to;
        dir_tab[0]  = '{2'b00, 16'hFFE0, 8'd5,   8'hF9, 1'b0, 1'b0, 18};
        dir_tab[1]  = '{2'b00, 16'd3,    8'd0,   8'h00, 1'b0, 1'b1, 1};
        dir_tab[2]  = '{2'b00, 16'd10,   8'd4,   8'h00, 1'b0, 1'b1, 18};
        dir_tab[3]  = '{2'b00, 16'd16387, 8'h80, 8'h80, 1'b0, 1'b0, 18};
        dir_tab[4]  = '{2'b00, 16'd131,  8'd1,   8'h00, 1'b0, 1'b1, 18};
        dir_tab[5]  = '{2'b01, 16'h1866, 8'h3C,  8'h5A, 1'b0, 1'b0, 1};
        dir_tab[6]  = '{2'b01, 16'h1966, 8'h3C,  8'h00, 1'b0, 1'b1, 1};
        dir_tab[7]  = '{2'b11, 16'd508,  8'd27,  8'd100, 1'b0, 1'b0, 1};
        dir_tab[8]  = '{2'b11, 16'd509,  8'd27,  8'h00, 1'b0, 1'b1, 1};
        dir_tab[9]  = '{2'b10, 16'd1,    8'd0,   8'h00, 1'b1, 1'b0, 1};
        dir_tab[10] = '{2'b10, 16'd5,    8'd0,   8'h00, 1'b0, 1'b1, 1};
        dir_tab[11] = '{2'b10, 16'hFFFF, 8'd0,   8'h00, 1'b0, 1'b0, 1};
        for (int i = 0; i < 12; i++) begin
            do_txn(dir_tab[i].c, dir_tab[i].r, dir_tab[i].b, a, gt, e, lat, irb, to);
            checks++;
            if (to) begin failures++; $display("FAIL dir%0d_timeout no out_valid in 40 cycles", i); end
            checks++;
            if (lat != dir_tab[i].lat) begin
                failures++; $display("FAIL dir%0d_latency got=%0d exp=%0d", i, lat, dir_tab[i].lat);
            end
            checks++;
            if (irb != 0) begin
                failures++; $display("FAIL dir%0d_in_ready_busy got=%0d high cycles exp=0", i, irb);
            end
            checks++;
            if ({a, gt, e} !== {dir_tab[i].a, dir_tab[i].gt, dir_tab[i].e}) begin
                failures++;
                $display("FAIL dir%0d_result got a=%h gt=%b err=%b exp a=%h gt=%b err=%b",
                         i, a, gt, e, dir_tab[i].a, dir_tab[i].gt, dir_tab[i].e);
            end
        end
    endtask

    task automatic test_random();
        logic [1:0] c; logic [15:0] r; logic [7:0] bb, xa, ea, a;
        logic egt, ee, gt, e; int ai, bi, lat, irb, elat; bit to;
        for (int i = 0; i < 80; i++) begin
            c  = 2'($urandom_range(0, 3));
            bb = 8'($urandom);
            if ($urandom_range(0, 7) == 0) bb = 8'h00;
            xa = 8'($urandom);
            ai = int'($signed(xa));
            bi = int'($signed(bb));
            if ($urandom_range(0, 1) == 1) begin
                case (c)
                    2'b00:   r = 16'(ai * bi + 3);
                    2'b01:   r = {xa & bb, xa ^ bb};
                    2'b11:   r = 16'((ai + bi) * 4);
                    default: r = ($urandom_range(0, 1) == 1) ? 16'h0001 : 16'hFFFF;
                endcase
            end else begin
                r = 16'($urandom);
            end
            model(c, r, bb, ea, egt, ee);
            elat = (c == 2'b00 && bb != 8'h00) ? 18 : 1;
            do_txn(c, r, bb, a, gt, e, lat, irb, to);
            checks++;
            if (to || lat != elat) begin
                failures++;
                $display("FAIL rnd%0d_latency ctrl=%b got=%0d exp=%0d", i, c, lat, elat);
            end
            checks++;
            if ({a, gt, e} !== {ea, egt, ee}) begin
                failures++;
                $display("FAIL rnd%0d_result ctrl=%b r=%h b=%h got a=%h gt=%b err=%b exp a=%h gt=%b err=%b",
                         i, c, r, bb, a, gt, e, ea, egt, ee);
            end
        end
    endtask

    task automatic test_backpressure();
        int bad;
        bus_if.ctrl = 2'b01; bus_if.result = 16'h1866; bus_if.b = 8'h3C; bus_if.in_valid = 1'b1;
        @(posedge clk); #1;
        bus_if.ctrl = 2'b11; bus_if.result = 16'd508; bus_if.b = 8'd27;
        bad = 0;
        for (int k = 0; k < 5; k++) begin
            if (bus_if.out_valid !== 1'b1 || bus_if.in_ready !== 1'b0 || bus_if.a_rec !== 8'h5A ||
                bus_if.err !== 1'b0 || bus_if.gt_flag !== 1'b0) bad++;
            @(posedge clk); #1;
        end
        checks++;
        if (bad != 0) begin
            failures++; $display("FAIL backpressure_stable got=%0d unstable cycles exp=0", bad);
        end
        bus_if.in_valid = 1'b0; bus_if.out_ready = 1'b1;
        @(posedge clk); #1;
        bus_if.out_ready = 1'b0;
        checks++;
        if (bus_if.out_valid !== 1'b0 || bus_if.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL backpressure_release got out_valid=%b in_ready=%b exp 0/1",
                     bus_if.out_valid, bus_if.in_ready);
        end
    endtask

    task automatic test_reset_mid_div();
        logic [7:0] a; logic gt, e; int lat, irb, bad; bit to;
        bus_if.ctrl = 2'b00; bus_if.result = 16'hFFE0; bus_if.b = 8'd5; bus_if.in_valid = 1'b1;
        @(posedge clk); #1;
        bus_if.in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        bad = 0;
        for (int k = 0; k < 25; k++) begin
            if (bus_if.out_valid !== 1'b0 || bus_if.in_ready !== 1'b1) bad++;
            @(posedge clk); #1;
        end
        checks++;
        if (bad != 0) begin
            failures++; $display("FAIL abort_no_output got=%0d bad cycles exp=0", bad);
        end
        checks++;
        if (bus_if.a_rec !== 8'h00 || bus_if.err !== 1'b0) begin
            failures++;
            $display("FAIL abort_cleared got a=%h err=%b exp 00/0", bus_if.a_rec, bus_if.err);
        end
        do_txn(2'b00, 16'hFFE0, 8'd5, a, gt, e, lat, irb, to);
        checks++;
        if (to || lat != 18 || {a, gt, e} !== {8'hF9, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL abort_recover got lat=%0d a=%h gt=%b err=%b exp lat=18 a=f9 gt=0 err=0",
                     lat, a, gt, e);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_reset_mid_div();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
